// File: rtl/uart_packet_rx.sv
// uart_packet_rx: drains bytes through the UART one-shot read handshake and parses
// SYNC/LEN/payload/CHK frames. Define PKT_TIMEOUT_EN to abandon stalled partial frames.
module uart_packet_rx #(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SYNC    = 8'hA5
`ifdef PKT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 100000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] rx_count,
  output logic        uart_read,
  input  logic [7:0]  uart_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_count
);
  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_RD    = 2'd1;
  localparam logic [1:0] F_SMP   = 2'd2;
  localparam logic [2:0] P_HUNT  = 3'd0;
  localparam logic [2:0] P_LEN   = 3'd1;
  localparam logic [2:0] P_PAY   = 3'd2;
  localparam logic [2:0] P_CHK   = 3'd3;
  localparam logic [2:0] P_DRAIN = 3'd4;

  logic [1:0]    fst_q, fst_d, rd_cnt_q, rd_cnt_d;
  logic [2:0]    pst_q, pst_d;
  logic [7:0]    len_q, len_d, chk_q, chk_d;
  logic [IW-1:0] idx_q, idx_d, rd_idx_q, rd_idx_d, idx_inc, rd_inc;
  logic [7:0]    pay_q [MAX_LEN];
  logic [7:0]    pay_d [MAX_LEN];
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          byte_v;
`ifdef PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Fetch: 3 clocks of read, then sample; the idle state keeps read low between requests.
  always_comb begin
    fst_d    = fst_q;
    rd_cnt_d = rd_cnt_q;
    case (fst_q)
      F_IDLE: if ((rx_count != '0) && (pst_q != P_DRAIN)) begin
        fst_d    = F_RD;
        rd_cnt_d = '0;
      end
      F_RD: if (rd_cnt_q == 2'd2) fst_d = F_SMP;
            else rd_cnt_d = rd_cnt_q + 2'd1;
      F_SMP:   fst_d = F_IDLE;
      default: fst_d = F_IDLE;
    endcase
  end

  assign uart_read = (fst_q == F_RD);
  assign byte_v    = (fst_q == F_SMP);

  always_comb begin
    pst_d         = pst_q;
    len_d         = len_q;
    chk_d         = chk_q;
    idx_d         = idx_q;
    rd_idx_d      = rd_idx_q;
    pay_d         = pay_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    frame_count_d = frame_count_q;
    idx_inc       = idx_q + IW'(1);
    rd_inc        = rd_idx_q + IW'(1);
    case (pst_q)
      P_HUNT: if (byte_v && (uart_data == SYNC)) pst_d = P_LEN;
      P_LEN: if (byte_v) begin
        if ((uart_data != 8'd0) && (uart_data <= MAX_LEN_B)) begin
          len_d = uart_data;
          chk_d = uart_data;
          idx_d = '0;
          pst_d = P_PAY;
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
          pst_d       = P_HUNT;
        end
      end
      P_PAY: if (byte_v) begin
        pay_d[idx_q[AW-1:0]] = uart_data;
        chk_d = chk_q ^ uart_data;
        idx_d = idx_inc;
        if (8'(idx_inc) == len_q) pst_d = P_CHK;
      end
      P_CHK: if (byte_v) begin
        if (uart_data == chk_q) begin
          pst_d       = P_DRAIN;
          rd_idx_d    = '0;
          out_valid_d = 1'b1;
          out_data_d  = pay_q[0];
          out_last_d  = (len_q == 8'd1);
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          pst_d       = P_HUNT;
        end
      end
      // out_valid_q is high for the whole drain, so ready alone completes a transfer.
      P_DRAIN: if (out_ready) begin
        if (out_last_q) begin
          out_valid_d   = 1'b0;
          out_last_d    = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          pst_d         = P_HUNT;
        end else begin
          rd_idx_d   = rd_inc;
          out_data_d = pay_q[rd_inc[AW-1:0]];
          out_last_d = (8'(rd_inc) == (len_q - 8'd1));
        end
      end
      default: pst_d = P_HUNT;
    endcase
`ifdef PKT_TIMEOUT_EN
    // A byte sampled this cycle clears the counter and so takes priority over expiry.
    tmo_d = '0;
    if (!byte_v && ((pst_q == P_LEN) || (pst_q == P_PAY) || (pst_q == P_CHK))) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        frame_err_d = 1'b1;
        err_code_d  = 2'd3;
        pst_d       = P_HUNT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fst_q         <= F_IDLE;
      rd_cnt_q      <= '0;
      pst_q         <= P_HUNT;
      len_q         <= '0;
      chk_q         <= '0;
      idx_q         <= '0;
      rd_idx_q      <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      frame_count_q <= '0;
`ifdef PKT_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      fst_q         <= fst_d;
      rd_cnt_q      <= rd_cnt_d;
      pst_q         <= pst_d;
      len_q         <= len_d;
      chk_q         <= chk_d;
      idx_q         <= idx_d;
      rd_idx_q      <= rd_idx_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_count_q <= frame_count_d;
`ifdef PKT_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    pay_q <= pay_d;
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: UART read-handshake model, frame-level reference parser,
// per-cycle output compare, and directed frames with literal expectations.
module tb_uart_packet_rx;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] rx_count = '0;
  logic        uart_read;
  logic [7:0]  uart_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_count;

  uart_packet_rx #(
    .MAX_LEN(MAX_LEN),
    .SYNC(SYNC)
`ifdef PKT_TIMEOUT_EN
    , .TIMEOUT(50)
`endif
  ) dut (
    .clock(clock), .reset(reset), .rx_count(rx_count), .uart_read(uart_read),
    .uart_data(uart_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_err(frame_err),
    .err_code(err_code), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART side: one-shot read, rearms only after read is seen low.
  byte unsigned fifo[$];
  bit armed = 1'b1;
  int rd_reqs = 0;
  always @(negedge clock) begin
    if (reset) armed = 1'b1;
    else if (uart_read && armed) begin
      rd_reqs++;
      check("read_nonempty", fifo.size() != 0, 1);
      if (fifo.size() != 0) uart_data = fifo.pop_front();
      armed = 1'b0;
    end else if (!uart_read) armed = 1'b1;
    rx_count = 11'(fifo.size());
  end

  // Reference: expected output stream and error codes from the frame rules.
  byte unsigned stim[$];
  byte unsigned exp_data[$];
  bit           exp_last[$];
  int           exp_err[$];
  int           exp_count = 0;
  byte unsigned got_data[$];
  bit           got_last[$];
  int           got_err[$];

  task automatic model_parse();
    int i = 0;
    int n = stim.size();
    int len;
    byte unsigned c;
    while (i < n) begin
      if (stim[i] != SYNC) begin i++; continue; end
      if (i + 1 >= n) begin
`ifdef PKT_TIMEOUT_EN
        exp_err.push_back(3);
`endif
        break;
      end
      len = int'(stim[i+1]);
      if (len == 0 || len > MAX_LEN) begin exp_err.push_back(1); i += 2; continue; end
      if (i + 2 + len >= n) begin
`ifdef PKT_TIMEOUT_EN
        exp_err.push_back(3);
`endif
        break;
      end
      c = byte'(len);
      for (int k = 0; k < len; k++) c ^= stim[i+2+k];
      if (stim[i+2+len] == c) begin
        for (int k = 0; k < len; k++) begin
          exp_data.push_back(stim[i+2+k]);
          exp_last.push_back(k == len - 1);
        end
        exp_count++;
      end else exp_err.push_back(2);
      i += 3 + len;
    end
  endtask

  int  run_len = 0;
  bit  hold = 1'b0;
  logic [7:0] hold_data;
  logic hold_last;
  always @(negedge clock) begin
    if (reset) begin
      run_len = 0;
      hold = 1'b0;
    end else begin
      if (uart_read) run_len++;
      else begin
        if (run_len != 0) check("read_len", run_len, 3);
        run_len = 0;
      end
      if (out_valid) begin
        check("read_in_drain", uart_read, 0);
        check("err_with_valid", frame_err, 0);
      end
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        check("out_expected", exp_data.size() != 0, 1);
        if (exp_data.size() != 0) begin
          check("out_data", out_data, exp_data.pop_front());
          check("out_last", out_last, exp_last.pop_front());
        end
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (frame_err) begin
        check("err_expected", exp_err.size() != 0, 1);
        if (exp_err.size() != 0) check("err_code", err_code, exp_err.pop_front());
        got_err.push_back(int'(err_code));
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    fifo.delete(); exp_data.delete(); exp_last.delete(); exp_err.delete();
    got_data.delete(); got_last.delete(); got_err.delete();
    exp_count = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic send_and_wait(input string name);
    int n = 0;
    model_parse();
    foreach (stim[k]) fifo.push_back(stim[k]);
    while ((fifo.size() != 0 || exp_data.size() != 0 || exp_err.size() != 0) && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_done"}, n < 3000, 1);
    repeat (30) @(posedge clock);
    #1;
    check({name, "_count"}, frame_count, exp_count);
  endtask

  task automatic check_seq(input string name, input byte unsigned want[$]);
    check({name, "_n"}, got_data.size(), want.size());
    foreach (want[k]) check({name, "_d"}, (k < got_data.size()) ? 9'(got_data[k]) : 9'h100, want[k]);
  endtask

  function automatic int last_mask();
    int m = 0;
    foreach (got_last[k]) if (got_last[k]) m |= (1 << k);
    return m;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte unsigned w[$];
    int n;
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_count", frame_count, 0);
    check("rst_read", uart_read, 0);

    // Read handshake with an empty FIFO, then one queued byte.
    repeat (20) @(posedge clock);
    #1 check("idle_no_read", rd_reqs, 0);
    fifo.push_back(8'h42);
    repeat (20) @(posedge clock);
    #1 check("one_read", rd_reqs, 1);
    check("one_drained", fifo.size(), 0);

    do_reset();
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_and_wait("good");
    check("good_model_count", exp_count, 1);
    w = '{8'h11, 8'h22, 8'h33};
    check_seq("good", w);
    check("good_last", last_mask(), 32'h4);
    check("good_frames", frame_count, 1);
    check("good_no_err", got_err.size(), 0);

    do_reset();
    stim = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_and_wait("cksum");
    check("cksum_err", (got_err.size() == 1) ? got_err[0] : -1, 2);
    check("cksum_code", err_code, 2);
    check("cksum_no_out", got_data.size(), 0);
    check("cksum_frames", frame_count, 0);

    do_reset();
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_and_wait("badlen");
    check("badlen_err", (got_err.size() == 1) ? got_err[0] : -1, 1);
    w = '{8'h7E};
    check_seq("badlen", w);
    check("badlen_last", last_mask(), 32'h1);
    check("badlen_frames", frame_count, 1);

    do_reset();
    stim = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44, 8'hA5, 8'h01, 8'h55, 8'h54};
    fork
      send_and_wait("bp");
      begin
        n = 0;
        while (got_data.size() < 2 && n < 2000) begin @(posedge clock); #1; n++; end
        check("bp_reach", n < 2000, 1);
        out_ready = 1'b0;
        repeat (10) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    w = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h55};
    check_seq("bp", w);
    check("bp_last", last_mask(), 32'h18);
    check("bp_frames", frame_count, 2);

    // LEN = MAX_LEN + 1 rejected, LEN = MAX_LEN accepted.
    do_reset();
    stim = '{8'hA5, 8'h11, 8'hA5, 8'h10};
    begin
      byte unsigned c = 8'h10;
      for (int k = 0; k < 16; k++) begin
        stim.push_back(8'(k * 3));
        c ^= 8'(k * 3);
      end
      stim.push_back(c);
    end
    send_and_wait("maxlen");
    check("maxlen_err", (got_err.size() == 1) ? got_err[0] : -1, 1);
    check("maxlen_n", got_data.size(), 16);
    check("maxlen_last", last_mask(), 32'h8000);
    check("maxlen_frames", frame_count, 1);

`ifdef PKT_TIMEOUT_EN
    do_reset();
    stim = '{8'hA5, 8'h02, 8'h11};
    send_and_wait("tmo");
    check("tmo_err", (got_err.size() == 1) ? got_err[0] : -1, 3);
    check("tmo_code", err_code, 3);
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_and_wait("tmo_next");
    check("tmo_next_frames", frame_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
